// File: rtl/ranging_pkg.sv
// Shared state encoding and timing constants for the ultrasonic ranging sequencer.
// Two constant sets are provided: the 50 MHz defaults and a scaled-down set for simulation.
package ranging_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_RISE = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] REPORT    = 3'd4;
  localparam logic [2:0] HOLDOFF   = 3'd5;

  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 1500000;
  localparam int DEF_PERIOD_CYCLES  = 3000000;
  localparam int DEF_CYCLES_PER_CM  = 2900;
  localparam int DEF_MAX_CM         = 400;
  localparam int DEF_DIST_W         = 9;

  localparam int SIM_TRIG_CYCLES    = 4;
  localparam int SIM_TIMEOUT_CYCLES = 200;
  localparam int SIM_PERIOD_CYCLES  = 500;
  localparam int SIM_CYCLES_PER_CM  = 10;
  localparam int SIM_MAX_CM         = 15;
  localparam int SIM_DIST_W         = 9;

endpackage

// File: rtl/ranging_controller_if.sv
// Sensor-side and result-side signals of the ranging controller.
// The controller uses the slave view; the driver of enable/echo uses the master view.
interface ranging_controller_if #(
  parameter int DIST_W = 9
);
  logic              enable;
  logic              echo;
  logic              trig;
  logic [DIST_W-1:0] distance;
  logic              valid;
  logic              timeout_flag;
  logic              busy;

  modport master (
    output enable, echo,
    input  trig, distance, valid, timeout_flag, busy
  );

  modport slave (
    input  enable, echo,
    output trig, distance, valid, timeout_flag, busy
  );
endinterface

// File: rtl/ranging_controller_edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus a delay flop for edge detection.
// level lags din by 2 clocks; rise/fall are single-cycle pulses aligned with level.
module edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta;
  logic level_q;
  logic dly;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta    <= 1'b0;
      level_q <= 1'b0;
      dly     <= 1'b0;
    end else begin
      meta    <= din;
      level_q <= meta;
      dly     <= level_q;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~dly;
  assign fall  = ~level_q & dly;
endmodule

// File: rtl/ranging_controller.sv
// Periodic trigger / echo-width ranging sequencer; distance in cm from a wrapping sub-counter.
// valid pulses during the REPORT cycle, one clock after echo fall (or timeout) is seen.
module ranging_controller
  import ranging_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
  parameter int MAX_CM         = DEF_MAX_CM,
  parameter int DIST_W         = DEF_DIST_W
) (
  input logic clock,
  input logic reset,
  ranging_controller_if.slave bus
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int WID_W   = $clog2(TIMEOUT_CYCLES);
  localparam int PER_W   = $clog2(PERIOD_CYCLES);
  localparam int SUB_W   = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WID_W-1:0]  WID_LAST  = WID_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [WID_W-1:0]  width;
  logic [PER_W-1:0]  period_cnt;
  logic [SUB_W-1:0]  sub;
  logic [DIST_W-1:0] cm;
  logic [DIST_W-1:0] distance_q;
  logic              valid_q;
  logic              timeout_q;
  logic              echo_s;
  logic              rise;
  logic              fall;

  edge_sync u_echo_sync (
    .clock (clock),
    .reset (reset),
    .din   (bus.echo),
    .level (echo_s),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      width      <= '0;
      period_cnt <= '0;
      sub        <= '0;
      cm         <= '0;
      distance_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state != IDLE) period_cnt <= period_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state      <= TRIG;
            cnt        <= '0;
            period_cnt <= '0;
          end
        end
        TRIG: begin
          if (cnt == TRIG_LAST) begin
            state <= WAIT_RISE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Edge-triggered: an echo already high here must fall and rise again.
        WAIT_RISE: begin
          if (rise) begin
            state <= MEASURE;
            cm    <= '0;
            sub   <= '0;
            width <= '0;
          end else if (cnt == WAIT_LAST) begin
            state      <= REPORT;
            distance_q <= CM_MAX;
            timeout_q  <= 1'b1;
            valid_q    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (fall) begin
            state      <= REPORT;
            distance_q <= cm;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b1;
          end else if (width == WID_LAST) begin
            state      <= REPORT;
            distance_q <= CM_MAX;
            timeout_q  <= 1'b1;
            valid_q    <= 1'b1;
          end else if (echo_s) begin
            width <= width + 1'b1;
            if (sub == SUB_LAST) begin
              sub <= '0;
              if (cm != CM_MAX) cm <= cm + 1'b1;
            end else begin
              sub <= sub + 1'b1;
            end
          end
        end
        REPORT: state <= HOLDOFF;
        HOLDOFF: begin
          if (period_cnt == PER_LAST) begin
            if (bus.enable) begin
              state      <= TRIG;
              cnt        <= '0;
              period_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // trig decodes the state flop so an asynchronous reset drops it immediately.
  assign bus.trig         = (state == TRIG);
  assign bus.busy         = (state != IDLE);
  assign bus.distance     = distance_q;
  assign bus.valid        = valid_q;
  assign bus.timeout_flag = timeout_q;
endmodule

// File: tb/tb_ranging_controller.sv
// Directed bench for ranging_controller using the scaled-down sim constants.
module tb_ranging_controller;
  import ranging_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  ranging_controller_if #(.DIST_W(SIM_DIST_W)) bus ();

  ranging_controller #(
    .TRIG_CYCLES    (SIM_TRIG_CYCLES),
    .TIMEOUT_CYCLES (SIM_TIMEOUT_CYCLES),
    .PERIOD_CYCLES  (SIM_PERIOD_CYCLES),
    .CYCLES_PER_CM  (SIM_CYCLES_PER_CM),
    .MAX_CM         (SIM_MAX_CM),
    .DIST_W         (SIM_DIST_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_trig(input logic level, input string tag, output int t);
    int n = 0;
    while (bus.trig !== level && n < 600) begin
      step();
      n++;
    end
    check(tag, 32'(bus.trig), 32'(level));
    t = cyc;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.valid !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    check(tag, 32'(bus.valid), 32'd1);
  endtask

  task automatic drive_echo(input int delay, input int width);
    repeat (delay) step();
    bus.echo = 1'b1;
    repeat (width) step();
    bus.echo = 1'b0;
  endtask

  initial begin
    int t0, t1, tf, te, trig_seen;
    bus.enable = 1'b0;
    bus.echo   = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_trig", 32'(bus.trig), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_distance", 32'(bus.distance), 0);
    check("rst_tflag", 32'(bus.timeout_flag), 0);
    reset = 1'b0;
    repeat (5) step();
    check("idle_busy_disabled", 32'(bus.busy), 0);

    // 1: 73-cycle echo -> 7 cm, 4-cycle trigger, 500-cycle period
    bus.enable = 1'b1;
    wait_trig(1'b1, "t1_trig_rise", t0);
    wait_trig(1'b0, "t1_trig_fall", tf);
    check("t1_trig_width", 32'(tf - t0), 4);
    drive_echo(20, 73);
    wait_valid("t1_valid_seen");
    check("t1_distance", 32'(bus.distance), 7);
    check("t1_tflag", 32'(bus.timeout_flag), 0);
    step();
    check("t1_valid_one_cycle", 32'(bus.valid), 0);
    check("t1_distance_held", 32'(bus.distance), 7);
    wait_trig(1'b1, "t1_next_trig", t1);
    check("t1_period", 32'(t1 - t0), 500);

    // 2: no echo -> timeout 200 cycles after trig falls
    wait_trig(1'b1, "t2_trig_rise", t0);
    wait_trig(1'b0, "t2_trig_fall", tf);
    wait_valid("t2_valid_seen");
    check("t2_valid_latency", 32'(cyc - tf), 200);
    check("t2_distance", 32'(bus.distance), 15);
    check("t2_tflag", 32'(bus.timeout_flag), 1);
    wait_trig(1'b1, "t2_next_trig", t1);
    check("t2_period", 32'(t1 - t0), 500);

    // 3a: 180-cycle echo saturates at 15 cm without timeout
    wait_trig(1'b1, "t3a_trig_rise", t0);
    wait_trig(1'b0, "t3a_trig_fall", tf);
    drive_echo(20, 180);
    wait_valid("t3a_valid_seen");
    check("t3a_distance", 32'(bus.distance), 15);
    check("t3a_tflag", 32'(bus.timeout_flag), 0);

    // 3b: echo held past the width limit -> timeout while echo still high
    wait_trig(1'b1, "t3b_trig_rise", t0);
    wait_trig(1'b0, "t3b_trig_fall", tf);
    repeat (20) step();
    bus.echo = 1'b1;
    te = cyc;
    wait_valid("t3b_valid_seen");
    check("t3b_valid_latency", 32'(cyc - te), 203);
    check("t3b_distance", 32'(bus.distance), 15);
    check("t3b_tflag", 32'(bus.timeout_flag), 1);
    bus.echo = 1'b0;

    // 4: echo high from TRIG onward is ignored; second pulse of 35 -> 3 cm
    wait_trig(1'b1, "t4_trig_rise", t0);
    bus.echo = 1'b1;
    wait_trig(1'b0, "t4_trig_fall", tf);
    repeat (10) step();
    bus.echo = 1'b0;
    drive_echo(10, 35);
    wait_valid("t4_valid_seen");
    check("t4_distance", 32'(bus.distance), 3);
    check("t4_tflag", 32'(bus.timeout_flag), 0);

    // 5: enable dropped mid-measurement; cycle completes, then idle
    wait_trig(1'b1, "t5_trig_rise", t0);
    wait_trig(1'b0, "t5_trig_fall", tf);
    repeat (20) step();
    bus.echo = 1'b1;
    repeat (20) step();
    bus.enable = 1'b0;
    repeat (30) step();
    bus.echo = 1'b0;
    wait_valid("t5_valid_seen");
    check("t5_distance", 32'(bus.distance), 4);
    check("t5_tflag", 32'(bus.timeout_flag), 0);
    trig_seen = 0;
    for (int n = 0; n < 600 && bus.busy === 1'b1; n++) begin
      step();
      if (bus.trig === 1'b1) trig_seen++;
    end
    check("t5_busy_low", 32'(bus.busy), 0);
    check("t5_busy_fall_time", 32'(cyc - t0), 500);
    repeat (20) begin
      step();
      if (bus.trig === 1'b1 || bus.busy === 1'b1) trig_seen++;
    end
    check("t5_no_trig_after", 32'(trig_seen), 0);

    // 6: asynchronous reset during MEASURE and during TRIG
    bus.enable = 1'b1;
    wait_trig(1'b1, "t6_trig_rise", t0);
    wait_trig(1'b0, "t6_trig_fall", tf);
    repeat (5) step();
    bus.echo = 1'b1;
    repeat (30) step();
    #2 reset = 1'b1;
    #1;
    check("t6m_trig", 32'(bus.trig), 0);
    check("t6m_busy", 32'(bus.busy), 0);
    check("t6m_valid", 32'(bus.valid), 0);
    check("t6m_distance", 32'(bus.distance), 0);
    step();
    reset = 1'b0;
    bus.echo = 1'b0;
    wait_trig(1'b1, "t6_trig_rise2", t0);
    repeat (2) step();
    check("t6_trig_before_rst", 32'(bus.trig), 1);
    #2 reset = 1'b1;
    #1;
    check("t6t_trig", 32'(bus.trig), 0);
    check("t6t_busy", 32'(bus.busy), 0);
    step();
    reset = 1'b0;
    wait_trig(1'b1, "t6_trig_rise3", t0);
    wait_trig(1'b0, "t6_trig_fall3", tf);
    check("t6_trig_width", 32'(tf - t0), 4);
    drive_echo(20, 73);
    wait_valid("t6_valid_seen");
    check("t6_distance", 32'(bus.distance), 7);
    check("t6_tflag", 32'(bus.timeout_flag), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
